// File: rtl/niu_alu_pkg.sv
// Shared definitions for the sequenced Niu ALU: function codes, FSM states
// and a constant-width helper.
package niu_alu_pkg;

  localparam int unsigned FN_SUB     = 5'b00000;
  localparam int unsigned FN_ADD     = 5'b00001;
  localparam int unsigned FN_MLT     = 5'b00010;
  localparam int unsigned FN_DIV     = 5'b00011;
  localparam int unsigned FN_NOT     = 5'b00100;
  localparam int unsigned FN_AND     = 5'b00101;
  localparam int unsigned FN_OR      = 5'b00110;
  localparam int unsigned FN_XOR     = 5'b00111;
  localparam int unsigned FN_SUL     = 5'b01000;
  localparam int unsigned FN_SSL     = 5'b01001;
  localparam int unsigned FN_SUR     = 5'b01010;
  localparam int unsigned FN_SSR     = 5'b01011;
  localparam int unsigned FN_EQ      = 5'b10000;
  localparam int unsigned FN_NEQ     = 5'b10001;
  localparam int unsigned FN_LT      = 5'b10010;
  localparam int unsigned FN_LEQ     = 5'b10011;
  localparam int unsigned FN_BYTESEL = 5'b11101;
  localparam int unsigned FN_BYTEINS = 5'b11110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/niu_alu_seq_muldiv.sv
// Iterative magnitude engine: MSB-first shift-add multiply (low word only)
// and restoring divide, one bit per cycle for WORD_SIZE cycles.
module niu_iter_muldiv
  import niu_alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 go_i,
  input  logic                 div_i,
  input  logic [WORD_SIZE-1:0] opa_i,
  input  logic [WORD_SIZE-1:0] opb_i,
  output logic                 finish_o,
  output logic [WORD_SIZE-1:0] mag_o
);

  localparam int unsigned CNT_BITS = clog2(WORD_SIZE);

  logic                 run_q;
  logic                 div_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic [WORD_SIZE-1:0] x_q, y_q, r_q;
  logic [WORD_SIZE-1:0] x_d, r_d;
  logic [WORD_SIZE:0]   trial;

  // x: multiplier (scanned from MSB) or dividend shifting into quotient;
  // y: multiplicand or divisor; r: product accumulator or remainder.
  always_comb begin
    trial = {r_q, x_q[WORD_SIZE-1]} - {1'b0, y_q};
    if (div_q) begin
      if (!trial[WORD_SIZE]) begin
        r_d = trial[WORD_SIZE-1:0];
        x_d = {x_q[WORD_SIZE-2:0], 1'b1};
      end else begin
        r_d = {r_q[WORD_SIZE-2:0], x_q[WORD_SIZE-1]};
        x_d = {x_q[WORD_SIZE-2:0], 1'b0};
      end
    end else begin
      r_d = (r_q << 1) + (x_q[WORD_SIZE-1] ? y_q : '0);
      x_d = x_q << 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      r_q   <= '0;
    end else if (go_i) begin
      run_q <= 1'b1;
      div_q <= div_i;
      cnt_q <= CNT_BITS'(WORD_SIZE - 1);
      x_q   <= div_i ? opa_i : opb_i;
      y_q   <= div_i ? opb_i : opa_i;
      r_q   <= '0;
    end else if (run_q) begin
      r_q   <= r_d;
      x_q   <= x_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign finish_o = run_q && (cnt_q == '0);
  assign mag_o    = div_q ? x_q : r_q;

endmodule

// File: rtl/niu_alu_seq.sv
// Start/done handshaked ALU: single-cycle ops resolve at accept, MLT/DIV run
// on the iterative magnitude engine followed by a sign-fix cycle.
module niu_alu_seq
  import niu_alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned OP_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OP_BITS-1:0]   func,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [7:0]           c,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 div_by_zero,
  output logic                 illegal
);

  localparam int unsigned BYTES    = WORD_SIZE / 8;
  localparam int unsigned SEL_BITS = clog2(BYTES);
  localparam int unsigned SH_BITS  = clog2(WORD_SIZE);

  state_e               state_q;
  logic                 busy_q, done_q, dbz_q, ill_q, neg_q;
  logic [WORD_SIZE-1:0] result_q;

  logic [WORD_SIZE-1:0] res_d, ins_word, mag_a, mag_b, iter_mag;
  logic [7:0]           sel_byte;
  logic [SH_BITS-1:0]   sh;
  logic [SEL_BITS-1:0]  idx;
  logic                 ill_d, dbz_d, iter_d, accept, iter_go, iter_finish;

  always_comb begin
    sh       = b[SH_BITS-1:0];
    idx      = b[SEL_BITS-1:0];
    sel_byte = '0;
    ins_word = a;
    // Byte index 0 addresses the most-significant byte.
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (idx == SEL_BITS'(i)) begin
        sel_byte                       = a[(BYTES-1-i)*8 +: 8];
        ins_word[(BYTES-1-i)*8 +: 8]   = c;
      end
    end
    res_d  = '0;
    ill_d  = 1'b0;
    dbz_d  = 1'b0;
    iter_d = 1'b0;
    case (func)
      OP_BITS'(FN_SUB):     res_d = a - b;
      OP_BITS'(FN_ADD):     res_d = a + b;
      OP_BITS'(FN_MLT):     iter_d = 1'b1;
      OP_BITS'(FN_DIV): begin
        if (b == '0) begin
          res_d = '1;
          dbz_d = 1'b1;
        end else begin
          iter_d = 1'b1;
        end
      end
      OP_BITS'(FN_NOT):     res_d = ~a;
      OP_BITS'(FN_AND):     res_d = a & b;
      OP_BITS'(FN_OR):      res_d = a | b;
      OP_BITS'(FN_XOR):     res_d = a ^ b;
      OP_BITS'(FN_SUL),
      OP_BITS'(FN_SSL):     res_d = a << sh;
      OP_BITS'(FN_SUR):     res_d = a >> sh;
      OP_BITS'(FN_SSR):     res_d = $signed(a) >>> sh;
      OP_BITS'(FN_EQ):      res_d = WORD_SIZE'(a == b);
      OP_BITS'(FN_NEQ):     res_d = WORD_SIZE'(a != b);
      OP_BITS'(FN_LT):      res_d = WORD_SIZE'($signed(a) < $signed(b));
      OP_BITS'(FN_LEQ):     res_d = WORD_SIZE'($signed(a) <= $signed(b));
      OP_BITS'(FN_BYTESEL): res_d = WORD_SIZE'(sel_byte);
      OP_BITS'(FN_BYTEINS): res_d = ins_word;
      default:              ill_d = 1'b1;
    endcase
  end

  assign accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign iter_go = accept && iter_d;
  assign mag_a   = a[WORD_SIZE-1] ? -a : a;
  assign mag_b   = b[WORD_SIZE-1] ? -b : b;

  niu_iter_muldiv #(
    .WORD_SIZE(WORD_SIZE)
  ) u_muldiv (
    .clk_i   (clk),
    .rst_i   (reset),
    .go_i    (iter_go),
    .div_i   (func == OP_BITS'(FN_DIV)),
    .opa_i   (mag_a),
    .opb_i   (mag_b),
    .finish_o(iter_finish),
    .mag_o   (iter_mag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (!accept) begin
            state_q <= ST_IDLE;
          end else if (iter_d) begin
            state_q <= (func == OP_BITS'(FN_DIV)) ? ST_DIV : ST_MUL;
            busy_q  <= 1'b1;
            neg_q   <= a[WORD_SIZE-1] ^ b[WORD_SIZE-1];
          end else begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= res_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_finish) state_q <= ST_FIX;
        end
        ST_FIX: begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= neg_q ? -iter_mag : iter_mag;
          dbz_q    <= 1'b0;
          ill_q    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign illegal     = ill_q;

endmodule

// File: doc/niu_alu_seq.md
Name: niu_alu_seq

Overview:
- Parametrised, sequenced ALU for the next-generation Niu multicycle core. Replaces the free-running ALU with a start/done handshaked unit.
- Generalised in word width.
- Adds iterative signed multiply and divide, a divide-by-zero flag, and a three-operand byte insert (no hidden state between ops).
- Sits behind the A/B latches of the core datapath; the control FSM issues start and waits for done before driving the result onto the bus.

Parameters:
WORD_SIZE, 32, datapath width in bits; multiple of 8, >= 16
OP_BITS, 5, width of func field
BYTES, WORD_SIZE/8, derived: bytes per word
SEL_BITS, clog2(BYTES), derived: byte-index width
SH_BITS, clog2(WORD_SIZE), derived: shift-amount width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only when busy=0
func  in  OP_BITS  operation code, sampled with start
a  in  WORD_SIZE  operand A (signed), sampled with start
b  in  WORD_SIZE  operand B (signed) / shift amount / byte index, sampled with start
c  in  8  insert byte for BYTEINS, sampled with start
busy  out  1  high from the cycle after accept until done
done  out  1  one-cycle pulse: result valid
result  out  WORD_SIZE  registered result; holds until next done
div_by_zero  out  1  registered; updated at every done; 1 only for DIV with b=0
illegal  out  1  registered; updated at every done; 1 for an unknown func

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, div_by_zero=0, illegal=0, internal counters cleared. Reset mid-operation abandons the op with no done pulse.
- Func encodings (shared package):
  - SUB=00000, ADD=00001, MLT=00010, DIV=00011, NOT=00100, AND=00101, OR=00110, XOR=00111
  - SUL=01000, SSL=01001, SUR=01010, SSR=01011
  - EQ=10000, NEQ=10001, LT=10010, LEQ=10011
  - BYTESEL=11101, BYTEINS=11110
  - All other codes are illegal.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE + start, single-cycle op: compute into result → DONE.
  - IDLE + start, MLT → MUL.
  - IDLE + start, DIV with b=0 → DONE (early out).
  - IDLE + start, DIV otherwise → DIV.
  - MUL/DIV run WORD_SIZE iterations (counter counts WORD_SIZE-1 down to 0), then → FIX.
  - FIX applies sign correction and writes result → DONE.
  - DONE asserts done for one cycle → IDLE.
- Latency, with start sampled at edge t:
  - Single-cycle ops: done high in cycle t+1.
  - MLT and DIV (b≠0): done high in cycle t+WORD_SIZE+2.
  - DIV with b=0: done high in cycle t+1.
- Back-to-back: start may be asserted during the done cycle (busy=0 in DONE) and is accepted.
- start while busy=1 is ignored; no queueing.
- Arithmetic (all results mod 2^WORD_SIZE):
  - ADD/SUB wrap.
  - MLT returns the low WORD_SIZE bits of the signed product (shift-add on magnitudes, negate if signs differ).
  - DIV: restoring division on magnitudes; quotient truncates toward zero.
  - DIV MIN/-1 returns MIN with no flag.
  - DIV by 0: result all-ones, div_by_zero=1.
- Shifts use b[SH_BITS-1:0] only.
  - SUL and SSL are identical logical left shifts.
  - SUR is logical right; SSR is arithmetic right.
- Compares are signed; result is 1 or 0, zero-extended.
- Byte index is b[SEL_BITS-1:0]; index 0 = most-significant byte [WORD_SIZE-1:WORD_SIZE-8].
  - BYTESEL: result = selected byte, zero-extended.
  - BYTEINS: result = a with the selected byte replaced by c.
- Illegal func: result=0, illegal=1, done at t+1.
- Operands are captured at accept; input changes while busy have no effect.

Decomposition:
- Package niu_alu_pkg: func localparams, FSM state enum, clog2 helper.
- One natural sub-module, niu_iter_muldiv: magnitude shift-add/restoring divider with its own counter, plus go/finish strobes. The top-level keeps the FSM, single-cycle ops, sign fix and flags.

Test Plan:
- Reset mid-MLT: start MLT a=7,b=9, assert reset at cycle 5 → no done; busy=0, result=0 immediately; next ADD 3+4 → done at t+1, result=7.
- Iterative ops, WORD_SIZE=32: MLT a=-6,b=7 → result=0xFFFFFFD6, done exactly 34 cycles after accept; DIV a=-7,b=2 → 0xFFFFFFFD; DIV 0x80000000/-1 → 0x80000000, div_by_zero=0.
- DIV 5/0 → done at t+1, result=0xFFFFFFFF, div_by_zero=1; following ADD → div_by_zero clears to 0.
- Byte ops: BYTESEL a=0x11223344,b=1 → 0x00000022; BYTEINS same a, b=3, c=0xAB → 0x112233AB.
- Shifts and compares: SSR 0x80000000 by 4 → 0xF8000000; SUR → 0x08000000; shift by b=36 → shift by 4; LT -1,1 → 1; LEQ 5,5 → 1.
- Handshake: start held high through a DIV → accepted once, later starts ignored while busy; start in the done cycle accepted; func=11000 → illegal=1, result=0; WORD_SIZE=16 rerun of MLT → done at t+18.
